// File: rtl/board_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// board_mem_arbiter_if
// Bundles every board-RAM sharing signal of board_mem_arbiter:
//   clear_req/clear_busy                     : board wipe control
//   disp_req/disp_addr/disp_data/disp_valid  : renderer cell fetch
//   game_req/game_we/game_addr/game_wdata/
//   game_ack/game_rdata                      : game logic read/write
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : single-port board RAM
// Modports:
//   slave  - the arbiter's view
//   master - the view of the clients and the RAM (used by the bench)
// ----------------------------------------------------------------------------
interface board_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 2
);
    logic              clear_req;
    logic              clear_busy;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic              game_ack;
    logic [DATA_W-1:0] game_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  clear_req, disp_req, disp_addr,
               game_req, game_we, game_addr, game_wdata, ram_rdata,
        output clear_busy, disp_data, disp_valid, game_ack, game_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output clear_req, disp_req, disp_addr,
               game_req, game_we, game_addr, game_wdata, ram_rdata,
        input  clear_busy, disp_data, disp_valid, game_ack, game_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// ----------------------------------------------------------------------------
// board_mem_arbiter
// Owns the single-port board RAM (2 bits/cell: 00 empty, 01 tri, 10 circle)
// and shares it between the renderer read path and the game read/write port.
// Wipes the board after reset and on every new-game request.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - board_mem_arbiter_if.slave: clear, display, game and RAM signals
// ----------------------------------------------------------------------------
module board_mem_arbiter #(
    parameter int unsigned CELLS      = 100,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    board_mem_arbiter_if.slave     bus
);
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    // one extra bit so CELLS == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0]       CELLS_L   = (ADDR_W + 1)'(CELLS);
    localparam logic [ADDR_W-1:0]     LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [STARVE_W-1:0]   STARVE_L  = STARVE_W'(STARVE_MAX);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt, w_clr_cnt_nxt;
    logic [STARVE_W-1:0] r_starve_cnt;

    logic                r_disp_valid, r_disp_oor;
    logic                r_game_ack, r_game_rd, r_game_oor;
    logic [DATA_W-1:0]   r_disp_hold, r_game_hold;

    logic                w_disp_in_range, w_game_in_range;
    logic                w_game_force, w_grant_disp, w_grant_game;
    logic [DATA_W-1:0]   w_disp_data, w_game_rdata;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state; a clear request during the wipe restarts it at 0
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (bus.clear_req) begin
                    w_clr_cnt_nxt = '0;
                end else if (r_clr_cnt == LAST_CELL) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.clear_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration and RAM drive
    // ------------------------------------------------------------------
    assign w_disp_in_range = ({1'b0, bus.disp_addr} < CELLS_L);
    assign w_game_in_range = ({1'b0, bus.game_addr} < CELLS_L);
    assign w_game_force    = bus.game_req && (r_starve_cnt == STARVE_L);
    assign w_grant_disp    = (r_state == ST_IDLE) && bus.disp_req && !w_game_force;
    assign w_grant_game    = (r_state == ST_IDLE) && bus.game_req && !w_grant_disp;

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (r_state == ST_CLEAR) begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = 1'b1;
            bus.ram_addr = r_clr_cnt;
        end else if (w_grant_disp) begin
            bus.ram_en   = w_disp_in_range;
            bus.ram_addr = bus.disp_addr;
        end else if (w_grant_game) begin
            bus.ram_en    = w_game_in_range;
            bus.ram_we    = w_game_in_range && bus.game_we;
            bus.ram_addr  = bus.game_addr;
            bus.ram_wdata = bus.game_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Completion pulses and read-data capture. RAM data arrives in the
    // cycle after the grant, so the outputs pass it straight through
    // during the pulse and a hold register keeps it afterwards.
    // ------------------------------------------------------------------
    assign w_disp_data  = r_disp_valid ? (r_disp_oor ? '1 : bus.ram_rdata) : r_disp_hold;
    assign w_game_rdata = (r_game_ack && r_game_rd) ?
                          (r_game_oor ? '1 : bus.ram_rdata) : r_game_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_valid <= 1'b0;
            r_disp_oor   <= 1'b0;
            r_game_ack   <= 1'b0;
            r_game_rd    <= 1'b0;
            r_game_oor   <= 1'b0;
            r_disp_hold  <= '0;
            r_game_hold  <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_disp_valid <= w_grant_disp;
            r_disp_oor   <= w_grant_disp && !w_disp_in_range;
            r_game_ack   <= w_grant_game;
            r_game_rd    <= w_grant_game && !bus.game_we;
            r_game_oor   <= w_grant_game && !w_game_in_range;
            r_disp_hold  <= w_disp_data;
            r_game_hold  <= w_game_rdata;
            if (bus.game_req && w_grant_disp) begin
                if (r_starve_cnt != STARVE_L)
                    r_starve_cnt <= r_starve_cnt + 1'b1;
            end else if (w_grant_game || !bus.game_req) begin
                r_starve_cnt <= '0;
            end
        end
    end

    assign bus.clear_busy = (r_state == ST_CLEAR);
    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_data  = w_disp_data;
    assign bus.game_ack   = r_game_ack;
    assign bus.game_rdata = w_game_rdata;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_board_mem_arbiter
// Directed bench for board_mem_arbiter with a behavioural single-port RAM.
// Inputs change on the falling edge; outputs are checked on the falling edge
// (registered) or 1 ns after it (combinational RAM drive).
// ----------------------------------------------------------------------------
module tb_board_mem_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [1:0] mem [128];

    board_mem_arbiter_if #(.ADDR_W(7), .DATA_W(2)) bus ();

    board_mem_arbiter #(
        .CELLS      (100),
        .ADDR_W     (7),
        .DATA_W     (2),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural board RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one game access starting at a falling edge; ends at a falling edge
    task automatic game_access(input logic we, input logic [6:0] addr, input logic [1:0] wd,
                               input logic exp_en, input logic [1:0] exp_rdata);
        bus.game_req   = 1'b1;
        bus.game_we    = we;
        bus.game_addr  = addr;
        bus.game_wdata = wd;
        #1;
        chk("game_ram_en", 32'(bus.ram_en), 32'(exp_en));
        if (exp_en)
            chk("game_ram_drive", {bus.ram_we, bus.ram_addr, bus.ram_wdata}, {we, addr, we ? wd : bus.ram_wdata});
        @(negedge clk);
        chk("game_ack", 32'(bus.game_ack), 32'd1);
        chk("game_rdata", 32'(bus.game_rdata), 32'(exp_rdata));
        bus.game_req = 1'b0;
        @(negedge clk);
        chk("game_ack_low", 32'(bus.game_ack), 32'd0);
        chk("game_rdata_hold", 32'(bus.game_rdata), 32'(exp_rdata));
    endtask

    task automatic disp_read(input logic [6:0] addr, input logic exp_en, input logic [1:0] exp_data);
        bus.disp_req  = 1'b1;
        bus.disp_addr = addr;
        #1;
        chk("disp_ram_en", 32'(bus.ram_en), 32'(exp_en));
        if (exp_en)
            chk("disp_ram_drive", {bus.ram_we, bus.ram_addr}, {1'b0, addr});
        @(negedge clk);
        chk("disp_valid", 32'(bus.disp_valid), 32'd1);
        chk("disp_data", 32'(bus.disp_data), 32'(exp_data));
        bus.disp_req = 1'b0;
        @(negedge clk);
        chk("disp_valid_low", 32'(bus.disp_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic [11:0] wipe_exp;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 128; i++) mem[i] = 2'b10;
        bus.clear_req  = 1'b0;
        bus.disp_req   = 1'b0;
        bus.disp_addr  = '0;
        bus.game_req   = 1'b0;
        bus.game_we    = 1'b0;
        bus.game_addr  = '0;
        bus.game_wdata = '0;
        bus.ram_rdata  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy", 32'(bus.clear_busy), 32'd1);
        chk("rst_outs", {bus.disp_valid, bus.game_ack, bus.disp_data, bus.game_rdata}, 32'd0);

        // automatic wipe after reset
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            wipe_exp = {1'b1, 1'b1, 1'b1, 7'(i), 2'b00};
            chk("wipe", {bus.clear_busy, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 32'(wipe_exp));
            @(negedge clk);
        end
        chk("wipe_done_busy", 32'(bus.clear_busy), 32'd0);
        chk("idle_ram_en", {bus.ram_en, bus.ram_we}, 32'd0);

        // write then read back
        game_access(1'b1, 7'd45, 2'b01, 1'b1, 2'b00);
        disp_read(7'd45, 1'b1, 2'b01);
        disp_read(7'd0, 1'b1, 2'b00);
        disp_read(7'd99, 1'b1, 2'b00);
        game_access(1'b0, 7'd45, 2'b00, 1'b1, 2'b01);

        // starvation: display held, game forced after 4 display grants
        bus.disp_req  = 1'b1;
        bus.disp_addr = 7'd3;
        bus.game_req  = 1'b1;
        bus.game_we   = 1'b0;
        bus.game_addr = 7'd45;
        #1;
        chk("starve_first_addr", 32'(bus.ram_addr), 32'd3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("starve_ack", 32'(bus.game_ack), 32'(k == 5));
            chk("starve_dvalid", 32'(bus.disp_valid), 32'(k <= 4));
            if (k == 4) begin
                #1;
                chk("starve_game_addr", 32'(bus.ram_addr), 32'd45);
            end
            if (k == 5) begin
                chk("starve_rdata", 32'(bus.game_rdata), 32'd1);
                bus.disp_req = 1'b0;
                bus.game_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("starve_quiet", {bus.disp_valid, bus.game_ack}, 32'd0);

        // out-of-range accesses
        game_access(1'b0, 7'd100, 2'b00, 1'b0, 2'b11);
        disp_read(7'd120, 1'b0, 2'b11);
        game_access(1'b1, 7'd100, 2'b10, 1'b0, 2'b11);
        game_access(1'b0, 7'd0, 2'b00, 1'b1, 2'b00);

        // clear request, then restart at clr_cnt=50
        game_access(1'b1, 7'd9, 2'b10, 1'b1, 2'b00);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        #1;
        chk("clr_start", {bus.clear_busy, bus.ram_addr}, {1'b1, 7'd0});
        repeat (50) @(negedge clk);
        #1;
        chk("clr_at50", 32'(bus.ram_addr), 32'd50);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        #1;
        chk("clr_restart", {bus.clear_busy, bus.ram_addr}, {1'b1, 7'd0});
        n = 0;
        while (bus.clear_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("clr_restart_len", 32'(n), 32'd100);
        disp_read(7'd9, 1'b1, 2'b00);

        // display grant and clear request in the same cycle
        game_access(1'b1, 7'd12, 2'b01, 1'b1, 2'b00);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 7'd12;
        bus.clear_req = 1'b1;
        #1;
        chk("dc_grant", {bus.ram_en, bus.ram_we, bus.ram_addr}, {1'b1, 1'b0, 7'd12});
        @(negedge clk);
        chk("dc_valid", {bus.disp_valid, bus.disp_data}, {1'b1, 2'b01});
        chk("dc_wipe", {bus.clear_busy, bus.ram_we, bus.ram_addr}, {1'b1, 1'b1, 7'd0});
        bus.disp_req  = 1'b0;
        bus.clear_req = 1'b0;
        n = 0;
        while (bus.clear_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("dc_wipe_len", 32'(n), 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
